mod_counter_updown_load: RTL and testbench
==========================================

// Module: mod_counter_updown_load
// PURPOSE
//  Parametrised runtime-modulus counter, successor to the fixed up-counting mod counter.
//  Adds up/down direction, parallel load, a cascadable terminal-count output and a registered wrap pulse.
//  Serves as the generic timebase/prescaler for sequential blocks; units chain via tc -> enable.
// PARAMETERS
//  BITS       4  counter width; Q, FINAL_VALUE and load_value are BITS wide
//  WRAP_BITS  8  width of wrap_cnt (present only with MOD_COUNTER_WRAP_CNT_EN)
// PORTS
//  clk          in   1          rising-edge clock, single clock domain
//  reset_n      in   1          asynchronous, active-low reset
//  enable       in   1          count enable; Q holds when low (load still works)
//  up_down      in   1          1 = count up, 0 = count down
//  load         in   1          synchronous parallel load strobe
//  load_value   in   BITS       value loaded when load=1
//  FINAL_VALUE  in   BITS       runtime modulus - 1; count range is 0..FINAL_VALUE
//  Q            out  BITS       current count, registered
//  tc           out  1          combinational terminal count, for cascading
//  wrap         out  1          registered one-cycle pulse after a wrap
//  wrap_cnt     out  WRAP_BITS  wrap counter (MOD_COUNTER_WRAP_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, reset_n=0): Q=0, wrap=0, wrap_cnt=0, immediately and independent of clk.
//  - Priority on each rising edge: load > enable > hold.
//  - load=1: Q <= min(load_value, FINAL_VALUE); wrap <= 0; ignores enable and up_down.
//  - enable=1, up_down=1: Q == FINAL_VALUE or Q > FINAL_VALUE -> Q <= 0, wrap <= 1; else Q <= Q+1.
//  - enable=1, up_down=0: Q == 0 -> Q <= FINAL_VALUE, wrap <= 1;
//    Q > FINAL_VALUE -> Q <= FINAL_VALUE, wrap <= 0; else Q <= Q-1.
//  - enable=0, load=0: Q holds; wrap <= 0.
//  - wrap is high exactly one cycle per wrap event, latency 1 cycle after the wrapping edge.
//  - tc = enable & ~load & ((up_down & Q>=FINAL_VALUE) | (~up_down & Q==0)).
//    tc is the pre-edge view of the wrap; it is high in the same cycle as the wrapping edge.
//  - FINAL_VALUE is sampled every cycle, with no shadow register. If lowered below Q mid-run,
//    the next enabled edge recovers as above, so Q never stays out of range more than 1 enabled edge.
//  - FINAL_VALUE=0: Q stays 0; each enabled edge is a wrap (wrap=1 continuously while enable=1).
//  - Direction change mid-count takes effect on the next edge with no extra latency.
//  - All arithmetic is BITS wide, unsigned; no carry leaves the counter other than through tc/wrap.
//  - Reset asserted mid-count aborts immediately; the first enabled edge after release counts from 0.
// CONFIGURATION
//  MOD_COUNTER_WRAP_CNT_EN defined:
//   - wrap_cnt port exists; it increments (mod 2^WRAP_BITS) on every edge that sets wrap <= 1.
//   - Cleared by reset only; load does not clear it.
//  MOD_COUNTER_WRAP_CNT_EN undefined: wrap_cnt port and its logic are absent; all else identical.
// TESTING
//  1. Reset at t=0, release at 2ns, enable=1, up_down=1, FINAL_VALUE=5:
//     Q 0,1,2,3,4,5,0,...; tc high while Q=5; wrap high the cycle after Q 5->0.
//  2. up_down=0, FINAL_VALUE=7 from Q=2: Q 2,1,0,7,6; tc high at Q=0; wrap pulses after 0->7.
//  3. load=1 with load_value=9, FINAL_VALUE=11: Q=9 next edge.
//     load_value=14 with FINAL_VALUE=11: Q=11 (clamped). load and enable together: load wins.
//  4. Q=9 counting up, FINAL_VALUE changed 11->5: next edge Q=0 with wrap; counting down instead: Q=5, no wrap.
//  5. FINAL_VALUE=0, enable=1 for 4 cycles: Q stays 0, wrap high 4 cycles.
//     enable=0: Q holds, tc=0, wrap=0.
//  6. reset_n pulsed low between edges at Q=4: Q=0 before the next edge.
//     With MOD_COUNTER_WRAP_CNT_EN, after 3 wraps wrap_cnt=3 and reset clears it to 0.

Source files
------------

// File: rtl/mod_counter_updown_load_if.sv
// Bus interface for mod_counter_updown_load.
// Groups the control inputs and count outputs of the counter. The counter's clock and
// reset stay plain module ports.
//   master : drives enable, up_down, load, load_value, FINAL_VALUE; observes Q, tc, wrap
//   slave  : the counter side (inverse directions)
// Optional: `define MOD_COUNTER_WRAP_CNT_EN adds the WRAP_BITS parameter and the wrap_cnt signal.
interface mod_counter_updown_load_if #(
    parameter int unsigned BITS = 4
`ifdef MOD_COUNTER_WRAP_CNT_EN
    ,
    parameter int unsigned WRAP_BITS = 8
`endif
);
    logic            enable;
    logic            up_down;
    logic            load;
    logic [BITS-1:0] load_value;
    logic [BITS-1:0] FINAL_VALUE;
    logic [BITS-1:0] Q;
    logic            tc;
    logic            wrap;
`ifdef MOD_COUNTER_WRAP_CNT_EN
    logic [WRAP_BITS-1:0] wrap_cnt;
`endif

    modport master (
        output enable, up_down, load, load_value, FINAL_VALUE,
`ifdef MOD_COUNTER_WRAP_CNT_EN
        input  wrap_cnt,
`endif
        input  Q, tc, wrap
    );

    modport slave (
        input  enable, up_down, load, load_value, FINAL_VALUE,
`ifdef MOD_COUNTER_WRAP_CNT_EN
        output wrap_cnt,
`endif
        output Q, tc, wrap
    );
endinterface

// File: rtl/mod_counter_updown_load.sv
// Runtime-modulus up/down counter with parallel load, cascadable terminal count and a
// registered wrap pulse. Count range is 0..FINAL_VALUE; units chain via tc -> enable.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears Q, wrap, wrap_cnt)
//   bus     : slave side of mod_counter_updown_load_if
//             (enable, up_down, load, load_value, FINAL_VALUE in; Q, tc, wrap[, wrap_cnt] out)
// Optional: `define MOD_COUNTER_WRAP_CNT_EN adds a WRAP_BITS-wide counter of wrap events.
module mod_counter_updown_load #(
    parameter int unsigned BITS = 4
`ifdef MOD_COUNTER_WRAP_CNT_EN
    ,
    parameter int unsigned WRAP_BITS = 8
`endif
) (
    input logic                        clk,
    input logic                        reset_n,
    mod_counter_updown_load_if.slave   bus
);
    logic [BITS-1:0] q_d, q_q;
    logic            wrap_d, wrap_q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            // Clamp so a load can never place the count outside 0..FINAL_VALUE.
            q_d = (bus.load_value > bus.FINAL_VALUE) ? bus.FINAL_VALUE : bus.load_value;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                // >= also recovers when FINAL_VALUE was lowered below the current count.
                if (q_q >= bus.FINAL_VALUE) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = bus.FINAL_VALUE;
                    wrap_d = 1'b1;
                end else if (q_q > bus.FINAL_VALUE) begin
                    // Out-of-range recovery while counting down is not a wrap.
                    q_d = bus.FINAL_VALUE;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef MOD_COUNTER_WRAP_CNT_EN
    logic [WRAP_BITS-1:0] wrap_cnt_d, wrap_cnt_q;

    // Load does not clear this; only reset does.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_d) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.wrap_cnt = wrap_cnt_q;
`endif

    assign bus.Q    = q_q;
    assign bus.wrap = wrap_q;
    // Pre-edge view of the wrap condition, for cascading into the next unit's enable.
    assign bus.tc   = bus.enable & ~bus.load &
                      ((bus.up_down & (q_q >= bus.FINAL_VALUE)) | (~bus.up_down & (q_q == '0)));
endmodule

// File: tb/tb_mod_counter_updown_load.sv
// Directed self-checking bench for mod_counter_updown_load (BITS=4).
module tb_mod_counter_updown_load;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

`ifdef MOD_COUNTER_WRAP_CNT_EN
    mod_counter_updown_load_if #(.BITS(4), .WRAP_BITS(8)) bus ();
    mod_counter_updown_load #(.BITS(4), .WRAP_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
`else
    mod_counter_updown_load_if #(.BITS(4)) bus ();
    mod_counter_updown_load #(.BITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0;
        bus.enable = 1'b1;
        bus.up_down = 1'b1;
        bus.load = 1'b0;
        bus.load_value = 4'd0;
        bus.FINAL_VALUE = 4'd5;
        #1;
        n_cmp++;
        if (bus.Q !== 4'd0) begin
            n_err++; $display("FAIL reset_q: got %0d, expected 0", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_err++; $display("FAIL reset_wrap: got %0b, expected 0", bus.wrap);
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        n_cmp++;
        if (bus.wrap_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_wrap_cnt: got %0d, expected 0", bus.wrap_cnt);
        end
`endif
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q [7];
        logic       exp_w [7];
        logic       exp_tc [7];
        exp_q  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        exp_w  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            #1;
            n_cmp++;
            if (bus.tc !== exp_tc[i]) begin
                n_err++; $display("FAIL up_tc[%0d]: got %0b, expected %0b", i, bus.tc, exp_tc[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.Q !== exp_q[i]) begin
                n_err++; $display("FAIL up_q[%0d]: got %0d, expected %0d", i, bus.Q, exp_q[i]);
            end
            n_cmp++;
            if (bus.wrap !== exp_w[i]) begin
                n_err++; $display("FAIL up_wrap[%0d]: got %0b, expected %0b", i, bus.wrap, exp_w[i]);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q [4];
        logic       exp_w [4];
        logic       exp_tc [4];
        exp_q  = '{4'd1, 4'd0, 4'd7, 4'd6};
        exp_w  = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
        bus.load = 1'b1;
        bus.load_value = 4'd2;
        bus.FINAL_VALUE = 4'd7;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd2) begin
            n_err++; $display("FAIL down_load_q: got %0d, expected 2", bus.Q);
        end
        bus.load = 1'b0;
        bus.up_down = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (bus.tc !== exp_tc[i]) begin
                n_err++; $display("FAIL down_tc[%0d]: got %0b, expected %0b", i, bus.tc, exp_tc[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.Q !== exp_q[i]) begin
                n_err++; $display("FAIL down_q[%0d]: got %0d, expected %0d", i, bus.Q, exp_q[i]);
            end
            n_cmp++;
            if (bus.wrap !== exp_w[i]) begin
                n_err++; $display("FAIL down_wrap[%0d]: got %0b, expected %0b", i, bus.wrap, exp_w[i]);
            end
        end
    endtask

    task automatic test_load();
        bus.load = 1'b1;
        bus.load_value = 4'd9;
        bus.FINAL_VALUE = 4'd11;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd9) begin
            n_err++; $display("FAIL load_9: got %0d, expected 9", bus.Q);
        end
        bus.load_value = 4'd14;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd11) begin
            n_err++; $display("FAIL load_clamp: got %0d, expected 11", bus.Q);
        end
        // Q == FINAL_VALUE counting up would wrap, but load has priority.
        bus.up_down = 1'b1;
        bus.load_value = 4'd3;
        #1;
        n_cmp++;
        if (bus.tc !== 1'b0) begin
            n_err++; $display("FAIL load_tc_masked: got %0b, expected 0", bus.tc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd3) begin
            n_err++; $display("FAIL load_wins_q: got %0d, expected 3", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_err++; $display("FAIL load_wins_wrap: got %0b, expected 0", bus.wrap);
        end
    endtask

    task automatic test_final_change();
        bus.load = 1'b1;
        bus.load_value = 4'd9;
        bus.FINAL_VALUE = 4'd11;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.up_down = 1'b1;
        bus.FINAL_VALUE = 4'd5;
        #1;
        n_cmp++;
        if (bus.tc !== 1'b1) begin
            n_err++; $display("FAIL fv_up_tc: got %0b, expected 1", bus.tc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd0) begin
            n_err++; $display("FAIL fv_up_q: got %0d, expected 0", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b1) begin
            n_err++; $display("FAIL fv_up_wrap: got %0b, expected 1", bus.wrap);
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        n_cmp++;
        if (bus.wrap_cnt !== 8'd3) begin
            n_err++; $display("FAIL wrap_cnt_3: got %0d, expected 3", bus.wrap_cnt);
        end
`endif
        bus.load = 1'b1;
        bus.FINAL_VALUE = 4'd11;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.up_down = 1'b0;
        bus.FINAL_VALUE = 4'd5;
        #1;
        n_cmp++;
        if (bus.tc !== 1'b0) begin
            n_err++; $display("FAIL fv_down_tc: got %0b, expected 0", bus.tc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd5) begin
            n_err++; $display("FAIL fv_down_q: got %0d, expected 5", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_err++; $display("FAIL fv_down_wrap: got %0b, expected 0", bus.wrap);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd4) begin
            n_err++; $display("FAIL fv_down_next: got %0d, expected 4", bus.Q);
        end
    endtask

    task automatic test_final_zero();
        bus.load = 1'b1;
        bus.load_value = 4'd5;
        bus.FINAL_VALUE = 4'd0;
        bus.up_down = 1'b1;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd0) begin
            n_err++; $display("FAIL fz_load_q: got %0d, expected 0", bus.Q);
        end
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (bus.tc !== 1'b1) begin
                n_err++; $display("FAIL fz_tc[%0d]: got %0b, expected 1", i, bus.tc);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.Q !== 4'd0) begin
                n_err++; $display("FAIL fz_q[%0d]: got %0d, expected 0", i, bus.Q);
            end
            n_cmp++;
            if (bus.wrap !== 1'b1) begin
                n_err++; $display("FAIL fz_wrap[%0d]: got %0b, expected 1", i, bus.wrap);
            end
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        n_cmp++;
        if (bus.wrap_cnt !== 8'd7) begin
            n_err++; $display("FAIL wrap_cnt_7: got %0d, expected 7", bus.wrap_cnt);
        end
`endif
        bus.enable = 1'b0;
        #1;
        n_cmp++;
        if (bus.tc !== 1'b0) begin
            n_err++; $display("FAIL hold_tc: got %0b, expected 0", bus.tc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd0) begin
            n_err++; $display("FAIL hold_q: got %0d, expected 0", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_err++; $display("FAIL hold_wrap: got %0b, expected 0", bus.wrap);
        end
    endtask

    task automatic test_reset_mid();
        bus.load = 1'b1;
        bus.load_value = 4'd4;
        bus.FINAL_VALUE = 4'd9;
        bus.enable = 1'b1;
        bus.up_down = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd4) begin
            n_err++; $display("FAIL rm_pre_q: got %0d, expected 4", bus.Q);
        end
        bus.load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.Q !== 4'd0) begin
            n_err++; $display("FAIL rm_async_q: got %0d, expected 0", bus.Q);
        end
`ifdef MOD_COUNTER_WRAP_CNT_EN
        n_cmp++;
        if (bus.wrap_cnt !== 8'd0) begin
            n_err++; $display("FAIL rm_wrap_cnt: got %0d, expected 0", bus.wrap_cnt);
        end
`endif
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.Q !== 4'd1) begin
            n_err++; $display("FAIL rm_post_q: got %0d, expected 1", bus.Q);
        end
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_err++; $display("FAIL rm_post_wrap: got %0b, expected 0", bus.wrap);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_final_change();
        test_final_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
